// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared CPU package: fetch states, prefix, reset vector, decode-side encodings
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OP      = 3'd1,
    ST_CB      = 3'd2,
    ST_IMM_LO  = 3'd3,
    ST_IMM_HI  = 3'd4,
    ST_HOLD    = 3'd5,
    ST_HALTED  = 3'd6
  } fetch_state_t;

  localparam logic [7:0]  CB_PREFIX    = 8'hCB;
  localparam logic [15:0] RESET_VECTOR = 16'h0000;

  localparam logic [1:0] OPLEN_0 = 2'd0;
  localparam logic [1:0] OPLEN_1 = 2'd1;
  localparam logic [1:0] OPLEN_2 = 2'd2;

  // Register-file and data-bus select encodings shared with decode
  typedef enum logic [2:0] {
    REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_HL_IND, REG_A
  } reg_sel_t;

  typedef enum logic [2:0] {
    DBUS_MEM, DBUS_ALU, DBUS_REG, DBUS_IMM_LO, DBUS_IMM_HI, DBUS_PC_LO, DBUS_PC_HI
  } dbus_sel_t;

endpackage

// File: rtl/fetch_unit_op_len.sv
// rtl/fetch_unit_op_len.sv - operand byte count for unprefixed opcodes
module op_len
  import fetch_unit_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  always_comb begin
    len = OPLEN_0;
    casez (opcode)
      8'b00??_?110,                         // LD r,d8
      8'b11??_?110,                         // ALU A,d8
      8'b001?_?000,                         // JR cc,r8
      8'h10, 8'h18,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:  len = OPLEN_1;
      8'b00??_0001,                         // LD rr,d16
      8'b110?_?010,                         // JP cc,a16
      8'b110?_?100,                         // CALL cc,a16
      8'h08, 8'hC3, 8'hCD,
      8'hEA, 8'hFA:                len = OPLEN_2;
      default:                     len = OPLEN_0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial instruction fetch: opcode, CB prefix and immediates to decode
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd_req,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rd_data,
  input  logic        mem_rd_ack,
  output logic [7:0]  op,
  output logic        op_cb,
  output logic [15:0] imm,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic        halt,
  input  logic        wake,
  output logic [15:0] pc
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  imm_q, imm_d;
  logic [7:0]   op_q, op_d;
  logic         op_cb_q, op_cb_d;
  logic [1:0]   len_q, len_d;
  logic [1:0]   byte_len;

  op_len u_op_len (
    .opcode (mem_rd_data),
    .len    (byte_len)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
      op_q    <= 8'h00;
      op_cb_q <= 1'b0;
      imm_q   <= 16'h0000;
      len_q   <= OPLEN_0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      op_cb_q <= op_cb_d;
      imm_q   <= imm_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    op_cb_d    = op_cb_q;
    imm_d      = imm_q;
    len_d      = len_q;
    mem_rd_req = 1'b0;
    op_valid   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_OP;

      ST_OP: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) begin
          pc_d    = pc_q + 16'd1;
          op_cb_d = 1'b0;
          imm_d   = 16'h0000;
          if (mem_rd_data == CB_PREFIX) begin
            state_d = ST_CB;
          end else begin
            op_d    = mem_rd_data;
            len_d   = byte_len;
            state_d = (byte_len == OPLEN_0) ? ST_HOLD : ST_IMM_LO;
          end
        end
      end

      ST_CB: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) begin
          pc_d    = pc_q + 16'd1;
          op_d    = mem_rd_data;
          op_cb_d = 1'b1;
          state_d = ST_HOLD;
        end
      end

      ST_IMM_LO: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) begin
          pc_d    = pc_q + 16'd1;
          imm_d   = {8'h00, mem_rd_data};
          state_d = (len_q == OPLEN_2) ? ST_IMM_HI : ST_HOLD;
        end
      end

      ST_IMM_HI: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) begin
          pc_d    = pc_q + 16'd1;
          imm_d   = {mem_rd_data, imm_q[7:0]};
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        op_valid = 1'b1;
        if (op_ready) state_d = halt ? ST_HALTED : ST_OP;
      end

      ST_HALTED: if (wake) state_d = ST_OP;

      default: state_d = ST_IDLE;
    endcase

    // Redirect wins everywhere; any byte acked this cycle is thrown away
    if (pc_load) begin
      pc_d    = pc_load_val;
      imm_d   = 16'h0000;
      op_d    = op_q;
      op_cb_d = op_cb_q;
      len_d   = len_q;
      state_d = ST_OP;
    end
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign op       = op_q;
  assign op_cb    = op_cb_q;
  assign imm      = imm_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against an instruction-level reference model
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_rd_ack;
  logic [7:0]  op;
  logic        op_cb;
  logic [15:0] imm;
  logic        op_valid;
  logic        op_ready;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        halt;
  logic        wake;
  logic [15:0] pc;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_rd_ack  (mem_rd_ack),
    .op          (op),
    .op_cb       (op_cb),
    .imm         (imm),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .halt        (halt),
    .wake        (wake),
    .pc          (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: instruction layout straight from the opcode listing
  logic [7:0] one_arg [26] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                               8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
                               8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                               8'hE0, 8'hF0, 8'hE8, 8'hF8};
  logic [7:0] two_arg [17] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
                               8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
                               8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA};

  typedef struct {
    logic [7:0]  op;
    logic        cb;
    logic [15:0] imm;
    logic [15:0] len;
  } inst_t;

  logic [7:0] mem [0:65535];

  function automatic int ref_len(input logic [7:0] b);
    int n = 0;
    foreach (one_arg[i]) if (one_arg[i] == b) n = 1;
    foreach (two_arg[i]) if (two_arg[i] == b) n = 2;
    return n;
  endfunction

  function automatic inst_t decode(input logic [15:0] a);
    inst_t r;
    logic [15:0] a1, a2;
    int n;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    if (mem[a] == 8'hCB) begin
      r.op = mem[a1]; r.cb = 1'b1; r.imm = 16'h0000; r.len = 16'd2;
    end else begin
      n = ref_len(mem[a]);
      r.op = mem[a]; r.cb = 1'b0;
      r.imm = (n == 0) ? 16'h0000 : (n == 1) ? {8'h00, mem[a1]} : {mem[a2], mem[a1]};
      r.len = 16'(n + 1);
    end
    return r;
  endfunction

  logic [15:0] model_pc;
  logic [15:0] nacks;
  bit          halted_m;
  int          wait_cnt;
  int          cur_delay;
  int          fixed_delay;
  int          handoffs;
  int          n;

  task automatic new_delay();
    cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
  endtask

  // Called at a falling edge: check settled outputs, drive inputs, advance model, wait one cycle
  task automatic drive_cycle(input bit ld, input logic [15:0] ld_val, input bit rdy,
                             input bit hlt, input bit wk);
    inst_t e;
    logic [15:0] ea, hp;
    bit ack, handoff, was_halted;
    e  = decode(model_pc);
    ea = model_pc + nacks;
    hp = model_pc + e.len;
    if (mem_rd_req) begin
      chk("req_addr", 32'(mem_addr), 32'(ea));
      chk("req_no_valid", 32'(op_valid), 32'd0);
    end
    if (op_valid) begin
      chk("op", 32'(op), 32'(e.op));
      chk("op_cb", 32'(op_cb), 32'(e.cb));
      chk("imm", 32'(imm), 32'(e.imm));
      chk("hold_pc", 32'(pc), 32'(hp));
    end
    if (halted_m) begin
      chk("halt_req", 32'(mem_rd_req), 32'd0);
      chk("halt_pc", 32'(pc), 32'(model_pc));
    end
    ack = mem_rd_req && (wait_cnt >= cur_delay);
    mem_rd_ack  = ack;
    mem_rd_data = ack ? mem[mem_addr] : 8'($urandom);
    op_ready    = rdy;
    pc_load     = ld;
    pc_load_val = ld_val;
    halt        = hlt;
    wake        = wk;
    handoff     = op_valid && rdy;
    was_halted  = halted_m;
    if (ld) begin
      model_pc = ld_val; nacks = 16'd0; halted_m = 1'b0;
      if (handoff) handoffs++;
    end else if (handoff) begin
      model_pc = hp; nacks = 16'd0; halted_m = hlt; handoffs++;
    end else begin
      if (ack) nacks = nacks + 16'd1;
      if (was_halted && wk) halted_m = 1'b0;
    end
    if (ack || ld) begin
      wait_cnt = 0;
      new_delay();
    end else if (mem_rd_req) begin
      wait_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!op_valid && cnt < 50) begin
      drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_rd_ack = 1'b0; mem_rd_data = 8'h00; op_ready = 1'b0;
    pc_load = 1'b0; pc_load_val = 16'h0000; halt = 1'b0; wake = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    model_pc = 16'h0000; nacks = 16'd0; halted_m = 1'b0;
    wait_cnt = 0; fixed_delay = 0; handoffs = 0;
    new_delay();
    repeat (2) @(negedge clk);

    chk("rst_req", 32'(mem_rd_req), 32'd0);
    chk("rst_valid", 32'(op_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_op", 32'(op), 32'h00);
    chk("rst_cb", 32'(op_cb), 32'd0);
    chk("rst_imm", 32'(imm), 32'h0000);

    // One-byte NOP straight out of reset
    mem[0] = 8'h00;
    rst = 1'b0;
    wait_valid(n);
    chk("lat_reset", 32'(n), 32'd2);
    chk("nop_pc", 32'(pc), 32'h0001);
    drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Three-byte jump, then redirect to its target
    mem[0] = 8'hC3; mem[1] = 8'h50; mem[2] = 8'h01;
    drive_cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    wait_valid(n);
    chk("lat_3byte", 32'(n), 32'd3);
    chk("jp_op", 32'(op), 32'hC3);
    chk("jp_imm", 32'(imm), 32'h0150);
    chk("jp_pc", 32'(pc), 32'h0003);
    drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("jp_single_handoff", 32'(op_valid), 32'd0);
    mem[16'h0150] = 8'hCB; mem[16'h0151] = 8'h37;
    drive_cycle(1'b1, 16'h0150, 1'b0, 1'b0, 1'b0);
    chk("redir_req", 32'(mem_rd_req), 32'd1);
    chk("redir_addr", 32'(mem_addr), 32'h0150);

    // CB-prefixed opcode
    wait_valid(n);
    chk("lat_cb", 32'(n), 32'd2);
    chk("cb_op", 32'(op), 32'h37);
    chk("cb_flag", 32'(op_cb), 32'd1);
    chk("cb_imm", 32'(imm), 32'h0000);
    chk("cb_pc", 32'(pc), 32'h0152);
    drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Slow memory: every byte acked three cycles late
    mem[16'h0200] = 8'h06; mem[16'h0201] = 8'h42;
    fixed_delay = 3;
    drive_cycle(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0);
    wait_valid(n);
    chk("lat_wait3", 32'(n), 32'd8);
    chk("slow_op", 32'(op), 32'h06);
    chk("slow_imm", 32'(imm), 32'h0042);
    drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Decode stalls in HOLD, then redirect collides with an acked byte
    fixed_delay = 0;
    new_delay();
    mem[16'h0202] = 8'h3E; mem[16'h0203] = 8'h99; mem[16'h0204] = 8'h00;
    wait_valid(n);
    chk("lat_ld_d8", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 32'(mem_rd_req), 32'd0);
      chk("stall_op", 32'(op), 32'h3E);
      chk("stall_imm", 32'(imm), 32'h0099);
      drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    end
    chk("stall_valid", 32'(op_valid), 32'd1);
    drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("drop_req", 32'(mem_rd_req), 32'd1);
    drive_cycle(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0);
    chk("drop_pc", 32'(pc), 32'h0300);
    chk("drop_addr", 32'(mem_addr), 32'h0300);
    chk("drop_op_kept", 32'(op), 32'h3E);

    // Wrap past 0xFFFF, halt at handoff, wake
    mem[16'hFFFF] = 8'h00;
    drive_cycle(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    wait_valid(n);
    chk("lat_1byte", 32'(n), 32'd1);
    chk("wrap_pc", 32'(pc), 32'h0000);
    drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("halted_req", 32'(mem_rd_req), 32'd0);
      chk("halted_valid", 32'(op_valid), 32'd0);
      drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    end
    drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("wake_req", 32'(mem_rd_req), 32'd1);
    chk("wake_addr", 32'(mem_addr), 32'h0000);

    // Reset while a slow request is outstanding; late ack must not count
    fixed_delay = 3;
    drive_cycle(1'b1, 16'h0400, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_req", 32'(mem_rd_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(mem_rd_req), 32'd0);
    chk("rst_async_pc", 32'(pc), 32'h0000);
    mem_rd_ack = 1'b1; mem_rd_data = 8'hCB; pc_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("late_ack_pc", 32'(pc), 32'h0000);
    chk("late_ack_addr", 32'(mem_addr), 32'h0000);
    chk("late_ack_op", 32'(op), 32'h00);
    mem_rd_ack = 1'b0;
    model_pc = 16'h0000; nacks = 16'd0; halted_m = 1'b0; wait_cnt = 0;
    fixed_delay = -1;
    new_delay();

    // Randomized traffic
    handoffs = 0;
    for (int i = 0; i < 4000; i++) begin
      bit ld;
      logic [15:0] val;
      ld  = ($urandom_range(0, 39) == 0);
      val = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
      drive_cycle(ld, val, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0);
    end
    chk("progress", 32'(handoffs > 150), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port clk  in  1  sole clock; every register samples on the rising edge.
REQ-003 Port rst  in  1  asynchronous, active-high reset.
REQ-004 Port mem_rd_req  out  1  byte read request to the memory bus.
REQ-005 Port mem_addr  out  16  read address; equals pc while mem_rd_req=1.
REQ-006 Port mem_rd_data  in  8  read data; valid in the cycle mem_rd_ack=1.
REQ-007 Port mem_rd_ack  in  1  read complete; may arrive in the same cycle as the request or any later cycle.
REQ-008 Port op  out  8  opcode to decode (second byte when CB-prefixed).
REQ-009 Port op_cb  out  1  op is a CB-prefixed opcode.
REQ-010 Port imm  out  16  immediate operand; {hi,lo}, zero when unused.
REQ-011 Port op_valid  out  1  op/op_cb/imm are valid.
REQ-012 Port op_ready  in  1  decode accepts the instruction; handoff = op_valid & op_ready.
REQ-013 Port pc_load  in  1  redirect (jump/call/ret/rst).
REQ-014 Port pc_load_val  in  16  redirect target.
REQ-015 Port halt  in  1  halt request from decode, sampled at handoff.
REQ-016 Port wake  in  1  leave HALTED (pending interrupt).
REQ-017 Port pc  out  16  address of the next byte to fetch.

Function
REQ-018 SHALL implement states IDLE, OP, CB, IMM_LO, IMM_HI, HOLD and HALTED.
REQ-019 IDLE SHALL go to OP unconditionally on the first clock after reset releases.
REQ-020 In OP, CB, IMM_LO and IMM_HI: mem_rd_req=1 and mem_addr=pc; on ack: latch the byte and pc<=pc+1 (16-bit wrap, 0xFFFF->0x0000).
REQ-021 OP on ack, in this order of checks:
- byte=0xCB -> CB
- else operand length 0 -> HOLD
- else operand length 1 -> IMM_LO
- else (length 2) -> IMM_LO
REQ-022 CB on ack SHALL set op=byte and op_cb=1, then go to HOLD; CB opcodes have no operands.
REQ-023 IMM_LO on ack SHALL set imm[7:0]; go to IMM_HI if length=2, else to HOLD with imm[15:8]=0.
REQ-024 IMM_HI on ack SHALL set imm[15:8], then go to HOLD.
REQ-025 HOLD SHALL drive op_valid=1 with op/op_cb/imm stable; mem_rd_req=0.
REQ-026 HOLD on handoff: go to HALTED if halt=1, else to OP; op_valid drops the next cycle.
REQ-027 HALTED: no requests; op_valid=0; go to OP when wake=1.
REQ-028 Operand length SHALL come from the op_len table (unprefixed opcodes only). Examples:
- 0x00 -> 0
- 0x06 -> 1
- 0x3E -> 1
- 0xE0 -> 1
- 0x01 -> 2
- 0xC3 -> 2
- 0xCD -> 2
- 0xEA -> 2
REQ-029 Zero-wait memory: a 1-byte op SHALL reach op_valid 1 cycle after entering OP; a 3-byte op 3 cycles after; a CB op 2 cycles after.
REQ-030 pc_load SHALL take priority in every state: pc<=pc_load_val, op_valid<=0, imm<=0, go to OP next cycle.
REQ-031 An ack coinciding with pc_load SHALL be discarded, with no latch and no increment.
REQ-032 pc_load coinciding with a handoff: decode has consumed the instruction; the redirect still applies.
REQ-033 mem_rd_req SHALL stay high until ack and SHALL NOT change address mid-request, except on pc_load.
REQ-034 op_valid SHALL never be asserted outside HOLD.

Reset
REQ-035 On rst: state=IDLE, pc=0x0000, op=0x00, op_cb=0, imm=0x0000, op_valid=0, mem_rd_req=0.
REQ-036 rst mid-fetch SHALL abandon the request immediately (mem_rd_req low asynchronously); a late ack after reset SHALL be ignored.

Structure
REQ-037 The shared CPU package SHALL hold:
- state encoding
- CB_PREFIX=8'hCB
- reset vector 16'h0000
- register and DBUS-select encodings, shared with decode
REQ-038 Operand length lookup SHALL be a combinational sub-module op_len (8-bit opcode in, 2-bit length out).

Verification
REQ-039 Reset, memory {0x00}, zero-wait, op_ready=1 -> op_valid at cycle 2 with op=0x00, imm=0; pc=0x0001.
REQ-040 Memory 0xC3,0x50,0x01 at 0x0000 -> single handoff with op=0xC3, imm=0x0150, pc=0x0003; then pc_load=1, val=0x0150 -> next request address 0x0150.
REQ-041 Memory 0xCB,0x37 -> op=0x37, op_cb=1, imm=0, pc=0x0002.
REQ-042 Ack delayed 3 cycles on each byte of 0x06,0x42 -> mem_addr stable while waiting; handoff with op=0x06, imm=0x0042.
REQ-043 op_ready=0 for 5 cycles in HOLD -> outputs held, no requests; pc_load during an outstanding request with a same-cycle ack -> byte dropped, pc=target.
REQ-044 pc=0xFFFF with a 1-byte op -> pc wraps to 0x0000; halt=1 at handoff -> no requests until wake=1, then fetch resumes at pc.
